// File: rtl/frogger_pkg.sv
// Shared types and wrap arithmetic for the frogger obstacle engine.
// Lane configuration layout and the screen-edge position update.
package frogger_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int X_W_DEF      = 10;
  localparam int SPD_W_DEF    = 4;
  localparam int DIV_W_DEF    = 4;

  typedef struct packed {
    logic [SPD_W_DEF-1:0] speed;
    logic [DIV_W_DEF-1:0] div;
    logic                 dir;
    logic [X_W_DEF-1:0]   len;
  } lane_cfg_t;

  // dir 0 moves toward +X, dir 1 toward -X; result stays in [0, sw)
  function automatic logic [15:0] wrap_add(
    input logic [15:0] x,
    input logic [15:0] eff,
    input logic        dir,
    input logic [15:0] sw
  );
    logic [15:0] nx;
    if (!dir) begin
      nx = x + eff;
      if (nx >= sw) nx = nx - sw;
    end else if (x < eff) begin
      nx = x + sw - eff;
    end else begin
      nx = x - eff;
    end
    return nx;
  endfunction

endpackage

// File: rtl/lane_unit.sv
// One playfield lane: config, frame divider, object positions
// and the wrapped frog hitbox compare.
module lane_unit
  import frogger_pkg::*;
#(
  parameter int NUM_OBJS = 3,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int LVL_W    = 3,
  parameter int LANE_IDX = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         tick_i,
  input  logic                         run_i,
  input  logic [LVL_W-1:0]             level_i,
  input  logic                         cfg_we_i,
  input  lane_cfg_t                    cfg_i,
  input  logic [X_W_DEF-1:0]           frog_x_i,
  output logic [NUM_OBJS*X_W_DEF-1:0]  obj_x_o,
  output logic                         hit_o,
  output logic                         moved_o
);

  localparam logic [15:0] SW16   = 16'(SCREEN_W);
  localparam logic [15:0] SPDMAX = 16'((1 << SPD_W_DEF) - 1);

  lane_cfg_t            cfg_q, cfg_d;
  logic [DIV_W_DEF-1:0] cnt_q, cnt_d;
  logic [X_W_DEF-1:0]   x_q [NUM_OBJS];
  logic [X_W_DEF-1:0]   x_d [NUM_OBJS];
  logic                 moved_q, moved_d;
  logic                 step;
  logic [15:0]          eff_sum, eff;
  logic [NUM_OBJS-1:0]  hit_v;

  assign eff_sum = 16'(cfg_q.speed) + 16'(level_i);
  assign eff     = (eff_sum > SPDMAX) ? SPDMAX : eff_sum;

  always_comb begin
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    if (tick_i && run_i) begin
      if (cnt_q == cfg_q.div) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // new config only takes effect for the next tick
    if (cfg_we_i) begin
      cfg_d = cfg_i;
      if (cfg_i.div < cnt_d) cnt_d = '0;
    end
    moved_d = step;
    for (int j = 0; j < NUM_OBJS; j++) begin
      x_d[j] = step ? X_W_DEF'(wrap_add(16'(x_q[j]), eff, cfg_q.dir, SW16))
                    : x_q[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q.speed <= SPD_W_DEF'(1);
      cfg_q.div   <= '0;
      cfg_q.dir   <= (LANE_IDX % 2) != 0;
      cfg_q.len   <= X_W_DEF'(32);
      cnt_q       <= '0;
      moved_q     <= 1'b0;
      for (int j = 0; j < NUM_OBJS; j++)
        x_q[j] <= X_W_DEF'(j * (SCREEN_W / NUM_OBJS));
    end else begin
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      moved_q <= moved_d;
      for (int j = 0; j < NUM_OBJS; j++)
        x_q[j] <= x_d[j];
    end
  end

  for (genvar j = 0; j < NUM_OBJS; j++) begin : g_obj
    logic [15:0] fx, ox, diff;
    assign fx   = 16'(frog_x_i);
    assign ox   = 16'(x_q[j]);
    assign diff = (fx >= ox) ? (fx - ox) : (fx + SW16 - ox);
    assign hit_v[j] = diff < 16'(cfg_q.len);
    assign obj_x_o[j*X_W_DEF +: X_W_DEF] = x_q[j];
  end

  assign hit_o   = |hit_v;
  assign moved_o = moved_q;

endmodule

// File: rtl/lane_scroller.sv
// Frogger obstacle engine: frame-tick sync, level counter,
// per-lane movers and the registered frog collision flag.
module lane_scroller
  import frogger_pkg::*;
#(
  parameter int NUM_LANES     = 8,
  parameter int OBJS_PER_LANE = 3,
  parameter int SCREEN_W      = SCREEN_W_DEF,
  parameter int X_W           = X_W_DEF,
  parameter int SPD_W         = SPD_W_DEF,
  parameter int DIV_W         = DIV_W_DEF,
  parameter int MAX_LEVEL     = 7,
  localparam int LN_W  = $clog2(NUM_LANES),
  localparam int LVL_W = $clog2(MAX_LEVEL + 1),
  localparam int LX_W  = OBJS_PER_LANE * X_W
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_clk,
  input  logic                            run,
  input  logic                            level_up,
  input  logic                            cfg_we,
  input  logic [LN_W-1:0]                 cfg_lane,
  input  logic [SPD_W-1:0]                cfg_speed,
  input  logic [DIV_W-1:0]                cfg_div,
  input  logic                            cfg_dir,
  input  logic [X_W-1:0]                  cfg_len,
  input  logic [X_W-1:0]                  frog_x,
  input  logic [LN_W-1:0]                 frog_lane,
  input  logic                            frog_valid,
  output logic [NUM_LANES*LX_W-1:0]       obj_x,
  output logic                            hit,
  output logic [NUM_LANES-1:0]            lane_moved,
  output logic [LVL_W-1:0]                level,
  output logic                            tick
);

  logic             fs1_q, fs2_q, fs3_q, tick_q;
  logic [LVL_W-1:0] level_q;
  logic             hit_q;
  logic [NUM_LANES-1:0] lane_hit;
  lane_cfg_t        wcfg;

  assign wcfg.speed = cfg_speed;
  assign wcfg.div   = cfg_div;
  assign wcfg.dir   = cfg_dir;
  assign wcfg.len   = cfg_len;

  // fs1/fs2 synchronise VGA_VS, fs3 holds the previous level for edge detect
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs1_q   <= 1'b0;
      fs2_q   <= 1'b0;
      fs3_q   <= 1'b0;
      tick_q  <= 1'b0;
      level_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      fs1_q  <= frame_clk;
      fs2_q  <= fs1_q;
      fs3_q  <= fs2_q;
      tick_q <= fs2_q & ~fs3_q;
      if (level_up && (level_q != LVL_W'(MAX_LEVEL)))
        level_q <= level_q + 1'b1;
      hit_q <= frog_valid & lane_hit[frog_lane];
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_unit #(
      .NUM_OBJS (OBJS_PER_LANE),
      .SCREEN_W (SCREEN_W),
      .LVL_W    (LVL_W),
      .LANE_IDX (l)
    ) u_lane (
      .clk_i    (Clk),
      .rst_i    (Reset),
      .tick_i   (tick_q),
      .run_i    (run),
      .level_i  (level_q),
      .cfg_we_i (cfg_we && (cfg_lane == LN_W'(l))),
      .cfg_i    (wcfg),
      .frog_x_i (frog_x),
      .obj_x_o  (obj_x[l*LX_W +: LX_W]),
      .hit_o    (lane_hit[l]),
      .moved_o  (lane_moved[l])
    );
  end

  assign hit   = hit_q;
  assign level = level_q;
  assign tick  = tick_q;

endmodule
